cpu_intc: RTL and testbench

Parametrised interrupt controller for the NES CPU, sitting between the external interrupt lines and the control unit (CU). It replaces the fixed single-line NMI/IRQ handling with N masked IRQ sources and NMI falling-edge detection. It arbitrates RESET/NMI/BRK/IRQ at instruction boundaries and sequences the 7-cycle interrupt entry with a committed vector. It also optionally implements 6502 NMI hijack of BRK/IRQ.

---
 rtl/cpu_intc.sv | 147 ++++++++++++++
 tb/tb_cpu_intc.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_intc.sv
// cpu_intc: NES CPU interrupt controller.
// Registers NMI falling edges, qualifies N_IRQ masked level IRQs, arbitrates
// RESET/NMI/BRK/IRQ at CU instruction boundaries (poll) and sequences the
// 7-cycle interrupt entry, pulsing vec_commit once the vector is final.
// Optional feature: define CPU_INTC_NMI_HIJACK_EN to let an NMI that becomes
// pending up to counter 3 of a BRK/IRQ entry take over its vector.
module cpu_intc #(
   parameter int          N_IRQ   = 4,
   parameter logic [15:0] RST_VEC = 16'hFFFC,
   parameter logic [15:0] NMI_VEC = 16'hFFFA,
   parameter logic [15:0] IRQ_VEC = 16'hFFFE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             nmi_n,
   input  logic [N_IRQ-1:0] irq_n,
   input  logic [N_IRQ-1:0] irq_mask,
   input  logic             i_flag,
   input  logic             brk_req,
   input  logic             poll,
   input  logic             ack,
   output logic             int_req,
   output logic [1:0]       int_type,
   output logic [15:0]      vector,
   output logic             b_flag,
   output logic             vec_commit,
   output logic             busy,
   output logic [N_IRQ-1:0] irq_pending,
   output logic             nmi_pending
);

   typedef enum logic [1:0] {RST_PEND, IDLE, REQ, SERVICE} state_e;
   typedef enum logic [1:0] {T_RESET, T_NMI, T_BRK, T_IRQ} itype_e;

   state_e      state_q, state_d;
   itype_e      type_q, type_d;
   logic [15:0] vec_q, vec_d;
   logic        bflag_q, bflag_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        nmi_cur_q, nmi_prev_q;
   logic        nmi_lat_q, nmi_lat_d;
   logic        nmi_edge, irq_qual, commit;

   assign irq_pending = ~irq_n & irq_mask;
   assign irq_qual    = (|irq_pending) & ~i_flag;
   assign nmi_edge    = nmi_prev_q & ~nmi_cur_q;
   assign commit      = (state_q == SERVICE) && (cnt_q == 3'd4);

   assign int_req     = (state_q == REQ) || (state_q == RST_PEND);
   assign busy        = (state_q == SERVICE);
   assign vec_commit  = commit;
   assign int_type    = type_q;
   assign vector      = vec_q;
   assign b_flag      = bflag_q;
   assign nmi_pending = nmi_lat_q;

   // NMI latch: a fresh edge wins over the clear at an NMI commit
   always_comb begin
      nmi_lat_d = nmi_lat_q;
      if (commit && (type_q == T_NMI)) nmi_lat_d = 1'b0;
      if (nmi_edge)                    nmi_lat_d = 1'b1;
   end

   // Arbitration and entry sequencing: next state, counter and request fields
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      type_d  = type_q;
      vec_d   = vec_q;
      bflag_d = bflag_q;
      case (state_q)
         RST_PEND: begin
            if (ack) begin
               state_d = SERVICE;
               cnt_d   = 3'd1;
            end
         end
         IDLE: begin
            if (poll) begin
               if (nmi_lat_q) begin
                  state_d = REQ;
                  type_d  = T_NMI;
                  vec_d   = NMI_VEC;
                  bflag_d = 1'b0;
               end else if (brk_req) begin
                  state_d = REQ;
                  type_d  = T_BRK;
                  vec_d   = IRQ_VEC;
                  bflag_d = 1'b1;
               end else if (irq_qual) begin
                  state_d = REQ;
                  type_d  = T_IRQ;
                  vec_d   = IRQ_VEC;
                  bflag_d = 1'b0;
               end
            end
         end
         REQ: begin
            if (ack) begin
               state_d = SERVICE;
               cnt_d   = 3'd1;
            end
         end
         SERVICE: begin
`ifdef CPU_INTC_NMI_HIJACK_EN
            // NMI takes over the vector of a BRK/IRQ entry; B keeps its value
            if (nmi_lat_q && (cnt_q <= 3'd3) && ((type_q == T_BRK) || (type_q == T_IRQ))) begin
               type_d = T_NMI;
               vec_d  = NMI_VEC;
            end
`endif
            if (cnt_q == 3'd6) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         default: state_d = RST_PEND;
      endcase
   end

   // State registers; NMI sampler tracks the line through reset so a line
   // held low across reset does not look like a new edge
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RST_PEND;
         type_q     <= T_RESET;
         vec_q      <= RST_VEC;
         bflag_q    <= 1'b0;
         cnt_q      <= '0;
         nmi_lat_q  <= 1'b0;
         nmi_cur_q  <= nmi_n;
         nmi_prev_q <= nmi_n;
      end else begin
         state_q    <= state_d;
         type_q     <= type_d;
         vec_q      <= vec_d;
         bflag_q    <= bflag_d;
         cnt_q      <= cnt_d;
         nmi_lat_q  <= nmi_lat_d;
         nmi_cur_q  <= nmi_n;
         nmi_prev_q <= nmi_cur_q;
      end
   end

endmodule

// File: tb/tb_cpu_intc.sv
// Bench for cpu_intc: driver issues polls/acks and pushes expected request and
// commit events; a negedge monitor pops and compares them as the DUT shows them.
module tb_cpu_intc;
   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          nmi_n = 1'b1;
   logic [N-1:0]  irq_n = '1;
   logic [N-1:0]  irq_mask = '0;
   logic          i_flag = 1'b0;
   logic          brk_req = 1'b0;
   logic          poll = 1'b0;
   logic          ack = 1'b0;
   logic          int_req, b_flag, vec_commit, busy, nmi_pending;
   logic [1:0]    int_type;
   logic [15:0]   vector;
   logic [N-1:0]  irq_pending;

   cpu_intc #(.N_IRQ(N), .RST_VEC(16'hFFFC), .NMI_VEC(16'hFFFA), .IRQ_VEC(16'hFFFE)) dut (
      .clk(clk), .rst(rst), .nmi_n(nmi_n), .irq_n(irq_n), .irq_mask(irq_mask),
      .i_flag(i_flag), .brk_req(brk_req), .poll(poll), .ack(ack),
      .int_req(int_req), .int_type(int_type), .vector(vector), .b_flag(b_flag),
      .vec_commit(vec_commit), .busy(busy), .irq_pending(irq_pending),
      .nmi_pending(nmi_pending)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;
   bit model_nmi = 1'b0;

   typedef struct {
      bit          kind;   // 0 request presented, 1 vector commit
      int          cy;
      logic [1:0]  t;
      logic [15:0] v;
      logic        b;
   } exp_t;
   exp_t exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, expv, cyc);
      end
   endtask

   task automatic push(input bit kind, input int cy, input logic [1:0] t, input logic [15:0] v, input logic b);
      exp_t e;
      e.kind = kind; e.cy = cy; e.t = t; e.v = v; e.b = b;
      exp_q.push_back(e);
   endtask

   task automatic mon_event(input bit kind);
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_%s: cycle %0d type %0d vector %h b %0b, nothing expected",
                  kind ? "commit" : "request", cyc, int_type, vector, b_flag);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.cy != cyc || e.t !== int_type || e.v !== vector || e.b !== b_flag) begin
            errors++;
            $display("FAIL %s_event: got kind %0d cycle %0d type %0d vector %h b %0b, expected kind %0d cycle %0d type %0d vector %h b %0b",
                     kind ? "commit" : "request", kind, cyc, int_type, vector, b_flag,
                     e.kind, e.cy, e.t, e.v, e.b);
         end
      end
   endtask

   // Monitor: a request is a rising int_req outside reset; a commit is vec_commit
   logic req_prev = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         req_prev = 1'b0;
      end else begin
         if (int_req && !req_prev) mon_event(1'b0);
         if (vec_commit)           mon_event(1'b1);
         req_prev = int_req;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit model_irq();
      return ((~irq_n & irq_mask) != '0) && !i_flag;
   endfunction

   // Produce a registered-and-latched NMI edge; latch is visible after return
   task automatic nmi_edge();
      if (nmi_n == 1'b0) begin
         nmi_n = 1'b1;
         tick();
      end
      nmi_n = 1'b0;
      tick();
      tick();
      model_nmi = 1'b1;
   endtask

   task automatic issue_poll(input bit brk, output bit got, output logic [1:0] t,
                             output logic [15:0] v, output logic b);
      int tp;
      tp = cyc;
      poll = 1'b1;
      brk_req = brk;
      #1;
      chk("irq_pending", 32'(irq_pending), 32'(~irq_n & irq_mask));
      chk("nmi_pending", 32'(nmi_pending), 32'(model_nmi));
      got = 1'b1;
      t = 2'd0; v = 16'h0000; b = 1'b0;
      if (model_nmi) begin
         t = 2'd1; v = 16'hFFFA; b = 1'b0;
      end else if (brk) begin
         t = 2'd2; v = 16'hFFFE; b = 1'b1;
      end else if (model_irq()) begin
         t = 2'd3; v = 16'hFFFE; b = 1'b0;
      end else begin
         got = 1'b0;
      end
      if (got) push(1'b0, tp + 1, t, v, b);
      tick();
      poll = 1'b0;
      brk_req = 1'b0;
      if (!got) begin
         chk("no_request_int_req", 32'(int_req), 0);
         chk("no_request_busy", 32'(busy), 0);
      end
   endtask

   // Ack now (cycle A) and step through the entry sequence.
   // nmi_off: drop nmi_n in cycle A+nmi_off; rst_off: assert rst in cycle A+rst_off.
   task automatic serve(input logic [1:0] ct, input logic [15:0] cv, input logic cb,
                        input int nmi_off, input int rst_off, input bit exp_commit);
      int a;
      a = cyc;
      ack = 1'b1;
      if (nmi_off == 0) nmi_n = 1'b0;
      if (exp_commit) push(1'b1, a + 4, ct, cv, cb);
      for (int k = 1; k <= 7; k++) begin
         tick();
         if (k == 1) begin
            ack = 1'b0;
            chk("ack_int_req_drop", 32'(int_req), 0);
            chk("ack_busy", 32'(busy), 1);
         end
         if (k == 2) begin
            poll = 1'b1;
            brk_req = 1'b1;
         end
         if (k == 3) begin
            poll = 1'b0;
            brk_req = 1'b0;
         end
         if (k == nmi_off) nmi_n = 1'b0;
         if (rst_off > 0 && k == rst_off + 1) begin
            rst = 1'b0;
            model_nmi = 1'b0;
            push(1'b0, cyc, 2'd0, 16'hFFFC, 1'b0);
            chk("abort_busy", 32'(busy), 0);
            chk("abort_vec_commit", 32'(vec_commit), 0);
            chk("abort_nmi_pending", 32'(nmi_pending), 0);
            chk("abort_int_req", 32'(int_req), 1);
            return;
         end
         if (k == rst_off) rst = 1'b1;
         if (k == 7) begin
            chk("end_busy", 32'(busy), 0);
            chk("end_int_req", 32'(int_req), 0);
         end
      end
      if (ct == 2'd1) model_nmi = 1'b0;
   endtask

   task automatic poll_and_serve(input bit brk);
      bit got;
      logic [1:0] t;
      logic [15:0] v;
      logic b;
      issue_poll(brk, got, t, v, b);
      if (got) begin
         repeat ($urandom_range(0, 2)) begin
            if ($urandom_range(0, 1) == 1) irq_n = N'($urandom);
            tick();
         end
         serve(t, v, b, -1, -1, 1'b1);
      end
   endtask

   task automatic summary();
      $display("Result: errors=%0d of %0d checks", errors, checks);
   endtask

   bit          got_m;
   logic [1:0]  t_m;
   logic [15:0] v_m;
   logic        b_m;

   initial begin
      // Reset release, RESET request held until ack two cycles later
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      model_nmi = 1'b0;
      push(1'b0, cyc, 2'd0, 16'hFFFC, 1'b0);
      tick();
      chk("rst_pend_int_req", 32'(int_req), 1);
      chk("rst_pend_type", 32'(int_type), 0);
      chk("rst_pend_vector", 32'(vector), 32'hFFFC);
      tick();
      chk("rst_pend_hold", 32'(int_req), 1);
      serve(2'd0, 16'hFFFC, 1'b0, -1, -1, 1'b1);

      // ack without a pending request is ignored
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("stray_ack_busy", 32'(busy), 0);
      chk("stray_ack_int_req", 32'(int_req), 0);

      // Masked IRQ qualifies; the same with I set does not
      irq_n = 4'b1101; irq_mask = 4'b0010; i_flag = 1'b0;
      poll_and_serve(1'b0);
      i_flag = 1'b1;
      poll_and_serve(1'b0);

      // NMI beats BRK; held-low line gives no second NMI
      irq_n = '1; i_flag = 1'b0;
      nmi_edge();
      poll_and_serve(1'b1);
      poll_and_serve(1'b0);

      // Poll in the edge cycle misses the latch, the next cycle sees it
      nmi_n = 1'b1;
      tick();
      nmi_n = 1'b0;
      tick();
      issue_poll(1'b0, got_m, t_m, v_m, b_m);
      model_nmi = 1'b1;
      poll_and_serve(1'b0);

      // NMI arriving during a BRK entry
      nmi_n = 1'b1;
      tick();
      issue_poll(1'b1, got_m, t_m, v_m, b_m);
`ifdef CPU_INTC_NMI_HIJACK_EN
      serve(2'd1, 16'hFFFA, 1'b1, 0, -1, 1'b1);
      issue_poll(1'b0, got_m, t_m, v_m, b_m);
`else
      serve(2'd2, 16'hFFFE, 1'b1, 0, -1, 1'b1);
      model_nmi = 1'b1;
      poll_and_serve(1'b0);
`endif

      // New NMI edge in the commit cycle of an NMI entry is kept
      nmi_edge();
      issue_poll(1'b0, got_m, t_m, v_m, b_m);
      nmi_n = 1'b1;
      serve(t_m, v_m, b_m, 3, -1, 1'b1);
      model_nmi = 1'b1;
      poll_and_serve(1'b0);

      // Reset at counter 3 of an IRQ entry with an NMI pending
      nmi_n = 1'b1; irq_n = 4'b1110; irq_mask = '1; i_flag = 1'b0;
      tick();
      issue_poll(1'b0, got_m, t_m, v_m, b_m);
      serve(t_m, v_m, b_m, 1, 3, 1'b0);
      tick();
      serve(2'd0, 16'hFFFC, 1'b0, -1, -1, 1'b1);

      // Randomised traffic
      for (int i = 0; i < 40; i++) begin
         irq_n    = N'($urandom);
         irq_mask = N'($urandom);
         i_flag   = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) nmi_edge();
         poll_and_serve($urandom_range(0, 3) == 0);
         repeat ($urandom_range(0, 2)) tick();
      end

      repeat (3) tick();
      chk("scoreboard_drained", 32'(exp_q.size()), 0);
      summary();
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
      summary();
      $fatal(1, "watchdog expired");
   end

endmodule
